// File: rtl/sprite_compositor_ctrl_if.sv
// -----------------------------------------------------------------------------
// sprite_compositor_ctrl_if
// Purpose : bundles the pixel stream, sprite RAM lookup port and composited
//           pixel output of sprite_compositor_ctrl into one interface.
// Modports: master - pixel timing / RAM side (drives frame_start, pixel_*,
//                    sprite_data, sprite_pixel; reads results)
//           slave  - the compositor itself
// Signals : frame_start, pixel_valid, pixel_x[9:0], pixel_y[9:0],
//           sprite_data[32N-1:0], sprite_pixel[32N-1:0], in_sprite[N-1:0],
//           rel_x[4N-1:0], rel_y[4N-1:0], out_valid, out_hit, out_pixel[31:0],
//           out_id[2:0], latch_busy
// Optional: SPRITE_COLLISION_EN adds coll_clear and coll_flags[N-1:0].
// -----------------------------------------------------------------------------
interface sprite_compositor_ctrl_if #(
  parameter int NUM_SPRITES = 4
);
  logic                     frame_start;
  logic                     pixel_valid;
  logic [9:0]               pixel_x;
  logic [9:0]               pixel_y;
  logic [32*NUM_SPRITES-1:0] sprite_data;
  logic [32*NUM_SPRITES-1:0] sprite_pixel;
  logic [NUM_SPRITES-1:0]   in_sprite;
  logic [4*NUM_SPRITES-1:0] rel_x;
  logic [4*NUM_SPRITES-1:0] rel_y;
  logic                     out_valid;
  logic                     out_hit;
  logic [31:0]              out_pixel;
  logic [2:0]               out_id;
  logic                     latch_busy;
`ifdef SPRITE_COLLISION_EN
  logic                     coll_clear;
  logic [NUM_SPRITES-1:0]   coll_flags;

  modport master (
    output frame_start, pixel_valid, pixel_x, pixel_y, sprite_data, sprite_pixel, coll_clear,
    input  in_sprite, rel_x, rel_y, out_valid, out_hit, out_pixel, out_id, latch_busy, coll_flags
  );
  modport slave (
    input  frame_start, pixel_valid, pixel_x, pixel_y, sprite_data, sprite_pixel, coll_clear,
    output in_sprite, rel_x, rel_y, out_valid, out_hit, out_pixel, out_id, latch_busy, coll_flags
  );
`else
  modport master (
    output frame_start, pixel_valid, pixel_x, pixel_y, sprite_data, sprite_pixel,
    input  in_sprite, rel_x, rel_y, out_valid, out_hit, out_pixel, out_id, latch_busy
  );
  modport slave (
    input  frame_start, pixel_valid, pixel_x, pixel_y, sprite_data, sprite_pixel,
    output in_sprite, rel_x, rel_y, out_valid, out_hit, out_pixel, out_id, latch_busy
  );
`endif
endinterface

// File: rtl/sprite_compositor_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_compositor_ctrl
// Purpose : per-pixel scheduler for NUM_SPRITES 16x16 sprite RAMs. Latches
//           every sprite's control word once per frame (staging -> shadow),
//           drives each RAM's lookup port and composites one sprite pixel per
//           clock with lowest-index-wins priority. Latency pixel -> out is 2.
// Ports   : HCLK   - clock
//           HRESET - asynchronous, active-high reset
//           bus    - sprite_compositor_ctrl_if.slave (pixel stream in, RAM
//                    lookup port, composited pixel out, latch_busy)
// Params  : NUM_SPRITES (1..8), TRANSPARENT (see-through pixel value)
// Macro   : SPRITE_COLLISION_EN - adds sticky per-sprite collision flags
//           (coll_flags) with a clear strobe (coll_clear).
// Control word: [9:0] x, [19:10] y, [31] enable, other bits ignored.
// -----------------------------------------------------------------------------
module sprite_compositor_ctrl #(
  parameter int          NUM_SPRITES = 4,
  parameter logic [31:0] TRANSPARENT = 32'h0000_0000
) (
  input logic                     HCLK,
  input logic                     HRESET,
  sprite_compositor_ctrl_if.slave bus
);

  localparam int N     = NUM_SPRITES;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Only enable, y and x are kept: bit 20 = enable, [19:10] = y, [9:0] = x.
  logic [N-1:0][31:0] sprite_data_s;
  logic [N-1:0][31:0] sprite_pixel_s;
  logic [N-1:0][20:0] staging_r;
  logic [N-1:0][20:0] shadow_r;
  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               latch_busy_r;
  logic               ctrl_unused_s;

  logic [N-1:0][10:0] dx_s;
  logic [N-1:0][10:0] dy_s;
  logic [N-1:0]       hit_s;
  logic [N-1:0][3:0]  rel_x_next_s;
  logic [N-1:0][3:0]  rel_y_next_s;

  logic [N-1:0]       in_sprite_r;
  logic [N-1:0][3:0]  rel_x_r;
  logic [N-1:0][3:0]  rel_y_r;
  logic               valid_d1_r;

  logic [N-1:0]       opaque_s;
  logic               win_found_s;
  logic [2:0]         win_id_s;
  logic [31:0]        win_pix_s;

  logic               out_valid_r;
  logic               out_hit_r;
  logic [31:0]        out_pixel_r;
  logic [2:0]         out_id_r;

  assign sprite_data_s  = bus.sprite_data;
  assign sprite_pixel_s = bus.sprite_pixel;

  // Reserved control-word bits are deliberately ignored.
  always_comb begin
    ctrl_unused_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      ctrl_unused_s = ctrl_unused_s ^ (^sprite_data_s[i][30:20]);
    end
  end

  // Control-word latch FSM: copies one sprite per cycle into staging, then
  // commits all staging words to the shadow set in a single cycle so active
  // video never sees a half-updated frame. A new frame_start while busy
  // restarts from sprite 0 and skips the commit of the aborted pass.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      latch_busy_r <= 1'b0;
      staging_r    <= {(21*N){1'b0}};
      shadow_r     <= {(21*N){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.frame_start) begin
            state_r      <= ST_LATCH;
            idx_r        <= {IDX_W{1'b0}};
            latch_busy_r <= 1'b1;
          end else begin
            latch_busy_r <= 1'b0;
          end
        end
        ST_LATCH: begin
          latch_busy_r <= 1'b1;
          if (bus.frame_start) begin
            idx_r <= {IDX_W{1'b0}};
          end else begin
            staging_r[idx_r] <= {sprite_data_s[idx_r][31], sprite_data_s[idx_r][19:0]};
            if (idx_r == LAST_IDX) begin
              state_r <= ST_COMMIT;
            end else begin
              idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_COMMIT: begin
          if (bus.frame_start) begin
            state_r      <= ST_LATCH;
            idx_r        <= {IDX_W{1'b0}};
            latch_busy_r <= 1'b1;
          end else begin
            shadow_r     <= staging_r;
            state_r      <= ST_IDLE;
            latch_busy_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          idx_r        <= {IDX_W{1'b0}};
          latch_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Hit test against the shadow positions. The 11-bit subtraction turns a
  // pixel left of / above the sprite into a large value, so one unsigned
  // compare covers both sides and clips sprites at the screen edge.
  always_comb begin
    dx_s         = {(11*N){1'b0}};
    dy_s         = {(11*N){1'b0}};
    hit_s        = {N{1'b0}};
    rel_x_next_s = {(4*N){1'b0}};
    rel_y_next_s = {(4*N){1'b0}};
    for (int i = 0; i < N; i++) begin
      dx_s[i]  = {1'b0, bus.pixel_x} - {1'b0, shadow_r[i][9:0]};
      dy_s[i]  = {1'b0, bus.pixel_y} - {1'b0, shadow_r[i][19:10]};
      hit_s[i] = shadow_r[i][20] & bus.pixel_valid &
                 (dx_s[i] < 11'd16) & (dy_s[i] < 11'd16);
      if (hit_s[i]) begin
        rel_x_next_s[i] = dx_s[i][3:0];
        rel_y_next_s[i] = dy_s[i][3:0];
      end else begin
        rel_x_next_s[i] = 4'd0;
        rel_y_next_s[i] = 4'd0;
      end
    end
  end

  // Stage 1: register the RAM lookup port and the pixel-valid flag.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      in_sprite_r <= {N{1'b0}};
      rel_x_r     <= {(4*N){1'b0}};
      rel_y_r     <= {(4*N){1'b0}};
      valid_d1_r  <= 1'b0;
    end else begin
      in_sprite_r <= hit_s;
      rel_x_r     <= rel_x_next_s;
      rel_y_r     <= rel_y_next_s;
      valid_d1_r  <= bus.pixel_valid;
    end
  end

  // Priority resolve: scanning from the top index down lets the lowest
  // opaque index overwrite the result last, so it wins.
  always_comb begin
    opaque_s    = {N{1'b0}};
    win_found_s = 1'b0;
    win_id_s    = 3'd0;
    win_pix_s   = TRANSPARENT;
    for (int i = 0; i < N; i++) begin
      opaque_s[i] = in_sprite_r[i] & (sprite_pixel_s[i] != TRANSPARENT);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (opaque_s[i]) begin
        win_found_s = 1'b1;
        win_id_s    = 3'(i);
        win_pix_s   = sprite_pixel_s[i];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Stage 2: register the composited pixel.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      out_valid_r <= 1'b0;
      out_hit_r   <= 1'b0;
      out_pixel_r <= 32'h0000_0000;
      out_id_r    <= 3'd0;
    end else begin
      out_valid_r <= valid_d1_r;
      out_hit_r   <= win_found_s;
      out_pixel_r <= win_pix_s;
      out_id_r    <= win_id_s;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [N-1:0] coll_set_s;
  logic [N-1:0] coll_flags_r;

  // A sprite collides when it is opaque and at least one other sprite is
  // opaque on the same pixel, i.e. two or more opaque sprites in total.
  always_comb begin
    coll_set_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      coll_set_s[i] = opaque_s[i] & ($countones(opaque_s) > 32'd1);
    end
  end

  // Sticky collision flags; a new set takes precedence over coll_clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      coll_flags_r <= {N{1'b0}};
    end else if (bus.coll_clear) begin
      coll_flags_r <= coll_set_s;
    end else begin
      coll_flags_r <= coll_flags_r | coll_set_s;
    end
  end

  assign bus.coll_flags = coll_flags_r;
`endif

  assign bus.in_sprite  = in_sprite_r;
  assign bus.rel_x      = rel_x_r;
  assign bus.rel_y      = rel_y_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_hit    = out_hit_r;
  assign bus.out_pixel  = out_pixel_r;
  assign bus.out_id     = out_id_r;
  assign bus.latch_busy = latch_busy_r;

endmodule

// File: tb/tb_sprite_compositor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor_ctrl
// Purpose : directed, table-driven self-checking bench for
//           sprite_compositor_ctrl (NUM_SPRITES = 4, TRANSPARENT = 0).
// Macro   : SPRITE_COLLISION_EN enables the collision-flag sequence.
// -----------------------------------------------------------------------------
module tb_sprite_compositor_ctrl;

  localparam int N = 4;
  localparam logic [31:0] P0 = 32'hAAAA_0001;
  localparam logic [31:0] P1 = 32'h1111_1111;
  localparam logic [31:0] P2 = 32'h2222_2222;
  localparam logic [31:0] P3 = 32'h3333_3333;

  logic HCLK = 1'b0;
  logic HRESET;

  sprite_compositor_ctrl_if #(.NUM_SPRITES(N)) bus ();

  sprite_compositor_ctrl #(
    .NUM_SPRITES (N),
    .TRANSPARENT (32'h0000_0000)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        pv;
    logic        tr1;
    logic        tr2;
    logic [3:0]  exp_in;
    logic [15:0] exp_rx;
    logic [15:0] exp_ry;
    logic        exp_hit;
    logic [31:0] exp_pix;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [31:0] cw(input logic en, input logic [9:0] x, input logic [9:0] y);
    return {en, 11'd0, y, x};
  endfunction

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic v);
    bus.pixel_x     = x;
    bus.pixel_y     = y;
    bus.pixel_valid = v;
  endtask

  task automatic set_ram(input logic tr1, input logic tr2);
    bus.sprite_pixel = {P3, tr2 ? 32'h0000_0000 : P2, tr1 ? 32'h0000_0000 : P1, P0};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_sprite"},  32'(bus.in_sprite),  32'd0);
    check({tag, "_rel_x"},      32'(bus.rel_x),      32'd0);
    check({tag, "_rel_y"},      32'(bus.rel_y),      32'd0);
    check({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
    check({tag, "_out_hit"},    32'(bus.out_hit),    32'd0);
    check({tag, "_out_pixel"},  bus.out_pixel,       32'd0);
    check({tag, "_out_id"},     32'(bus.out_id),     32'd0);
    check({tag, "_latch_busy"}, 32'(bus.latch_busy), 32'd0);
`ifdef SPRITE_COLLISION_EN
    check({tag, "_coll_flags"}, 32'(bus.coll_flags), 32'd0);
`endif
  endtask

  // Counts busy cycles from the current point until latch_busy drops (bounded).
  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    while (bus.latch_busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
    check("latch_busy_drop", 32'(bus.latch_busy), 32'd0);
  endtask

  task automatic load_frame(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            output int busy_cycles);
    bus.sprite_data = {d3, d2, d1, d0};
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    wait_idle(busy_cycles);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    string t;
    t = $sformatf("v%0d", k);
    set_pix(v.px, v.py, v.pv);
    set_ram(v.tr1, v.tr2);
    tick();
    check({t, "_in_sprite"}, 32'(bus.in_sprite), 32'(v.exp_in));
    check({t, "_rel_x"},     32'(bus.rel_x),     32'(v.exp_rx));
    check({t, "_rel_y"},     32'(bus.rel_y),     32'(v.exp_ry));
    tick();
    check({t, "_out_valid"}, 32'(bus.out_valid), 32'(v.pv));
    check({t, "_out_hit"},   32'(bus.out_hit),   32'(v.exp_hit));
    check({t, "_out_pixel"}, bus.out_pixel,      v.exp_pix);
    check({t, "_out_id"},    32'(bus.out_id),    32'(v.exp_id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;

    // Config A: s0 (100,50), s1 (200,200), s2 (195,195), s3 (630,300).
    //          px     py      pv    tr1   tr2   in     rel_x     rel_y     hit   pixel  id
    vecs[0]  = '{10'd115, 10'd65,  1'b1, 1'b0, 1'b0, 4'b0001, 16'h000F, 16'h000F, 1'b1, P0,    3'd0};
    vecs[1]  = '{10'd116, 10'd65,  1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 32'd0, 3'd0};
    vecs[2]  = '{10'd100, 10'd50,  1'b1, 1'b0, 1'b0, 4'b0001, 16'h0000, 16'h0000, 1'b1, P0,    3'd0};
    vecs[3]  = '{10'd99,  10'd50,  1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 32'd0, 3'd0};
    vecs[4]  = '{10'd115, 10'd66,  1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 32'd0, 3'd0};
    vecs[5]  = '{10'd200, 10'd200, 1'b1, 1'b0, 1'b0, 4'b0110, 16'h0500, 16'h0500, 1'b1, P1,    3'd1};
    vecs[6]  = '{10'd200, 10'd200, 1'b1, 1'b1, 1'b0, 4'b0110, 16'h0500, 16'h0500, 1'b1, P2,    3'd2};
    vecs[7]  = '{10'd639, 10'd300, 1'b1, 1'b0, 1'b0, 4'b1000, 16'h9000, 16'h0000, 1'b1, P3,    3'd3};
    vecs[8]  = '{10'd0,   10'd300, 1'b1, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 32'd0, 3'd0};
    vecs[9]  = '{10'd115, 10'd65,  1'b0, 1'b0, 1'b0, 4'b0000, 16'h0000, 16'h0000, 1'b0, 32'd0, 3'd0};
    vecs[10] = '{10'd210, 10'd210, 1'b1, 1'b0, 1'b0, 4'b0110, 16'h0FA0, 16'h0FA0, 1'b1, P1,    3'd1};
    vecs[11] = '{10'd211, 10'd200, 1'b1, 1'b0, 1'b0, 4'b0010, 16'h00B0, 16'h0000, 1'b1, P1,    3'd1};
    vecs[12] = '{10'd200, 10'd200, 1'b1, 1'b1, 1'b1, 4'b0110, 16'h0500, 16'h0500, 1'b0, 32'd0, 3'd0};

    HRESET          = 1'b1;
    bus.frame_start = 1'b0;
    bus.sprite_data = {(32*N){1'b0}};
    set_pix(10'd0, 10'd0, 1'b0);
    set_ram(1'b0, 1'b0);
`ifdef SPRITE_COLLISION_EN
    bus.coll_clear  = 1'b0;
`endif
    tick();
    tick();
    check_all_zero("rst");
    HRESET = 1'b0;

    // Sprite 0 at (0,0): pixel (5,5) hits.
    load_frame(cw(1'b1, 10'd0, 10'd0), 32'd0, 32'd0, 32'd0, bc);
    check("first_latch_cycles", 32'(bc), 32'd5);
    set_pix(10'd5, 10'd5, 1'b1);
    tick();
    tick();
    check("pre_reset_hit", 32'(bus.out_hit), 32'd1);

    // Asynchronous reset mid-stream clears everything without a clock edge.
    HRESET = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    HRESET = 1'b0;

    // Shadow is reset: pixel (5,5) right after frame_start must not hit.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
    check("shadow_reset_hit", 32'(bus.out_hit), 32'd0);
    check("shadow_reset_valid", 32'(bus.out_valid), 32'd1);
    wait_idle(bc);
    tick();
    tick();
    check("post_commit_hit", 32'(bus.out_hit), 32'd1);
    set_pix(10'd0, 10'd0, 1'b0);

    // Restart: a frame_start during LATCH restarts with the new data.
    bus.sprite_data = {32'd0, 32'd0, 32'd0, cw(1'b1, 10'd400, 10'd400)};
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    tick();
    check("restart_busy_mid", 32'(bus.latch_busy), 32'd1);
    bus.sprite_data = {cw(1'b1, 10'd630, 10'd300), cw(1'b1, 10'd195, 10'd195),
                       cw(1'b1, 10'd200, 10'd200), cw(1'b1, 10'd100, 10'd50)};
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    wait_idle(bc);
    check("restart_latch_cycles", 32'(bc), 32'd5);

    // Changing sprite 0 without frame_start must not affect the shadow.
    bus.sprite_data[31:0] = cw(1'b0, 10'd0, 10'd0);

    for (int k = 0; k < 13; k++) begin
      run_vec(k, vecs[k]);
    end

    // Sprite 0 disabled: no hit on its former area.
    load_frame(cw(1'b0, 10'd100, 10'd50), cw(1'b1, 10'd200, 10'd200),
               cw(1'b1, 10'd195, 10'd195), cw(1'b1, 10'd630, 10'd300), bc);
    check("disable_latch_cycles", 32'(bc), 32'd5);
    set_ram(1'b0, 1'b0);
    set_pix(10'd115, 10'd65, 1'b1);
    tick();
    check("disable_in_a", 32'(bus.in_sprite), 32'd0);
    tick();
    check("disable_hit_a", 32'(bus.out_hit), 32'd0);
    set_pix(10'd100, 10'd50, 1'b1);
    tick();
    tick();
    check("disable_hit_b", 32'(bus.out_hit), 32'd0);
    check("disable_pix_b", bus.out_pixel, 32'd0);

`ifdef SPRITE_COLLISION_EN
    // Sprites 0 and 3 overlap at (306,306).
    load_frame(cw(1'b1, 10'd300, 10'd300), 32'd0, 32'd0, cw(1'b1, 10'd305, 10'd305), bc);
    bus.coll_clear = 1'b0;
    set_pix(10'd306, 10'd306, 1'b1);
    tick();
    tick();
    check("coll_set", 32'(bus.coll_flags), 32'h9);
    check("coll_winner", 32'(bus.out_id), 32'd0);
    set_pix(10'd0, 10'd0, 1'b0);
    tick();
    tick();
    tick();
    check("coll_sticky", 32'(bus.coll_flags), 32'h9);
    bus.coll_clear = 1'b1;
    tick();
    bus.coll_clear = 1'b0;
    check("coll_clear", 32'(bus.coll_flags), 32'h0);
    set_pix(10'd306, 10'd306, 1'b1);
    tick();
    bus.coll_clear = 1'b1;
    tick();
    bus.coll_clear = 1'b0;
    check("coll_set_over_clear", 32'(bus.coll_flags), 32'h9);
    set_pix(10'd0, 10'd0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
